// File: rtl/i8mac_seq.sv
// Job sequencer for an NCH-lane int8 MAC array: clear, accumulate LEN operands, drain, collect.
// Optional build macro SEQ_PERF_EN adds a 32-bit stall counter output (stall_cnt_o).
module i8mac_seq #(
    parameter int unsigned NCH = 8,
    parameter int unsigned AW  = 20,
    parameter int unsigned LW  = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [LW-1:0]    len_i,
    input  logic [LW-1:0]    npix_i,
    input  logic [AW-1:0]    in_base_i,
    input  logic [AW-1:0]    in_stride_i,
    output logic [AW-1:0]    in_addr_o,
    output logic [AW-1:0]    fil_addr_o,
    input  logic             mem_rdy_i,
    output logic             mac_xreset_o,
    output logic [NCH-1:0]   mac_rdy_o,
    output logic [NCH-1:0]   mac_aen_o,
    output logic [NCH-1:0]   mac_acl_o,
    output logic [NCH-1:0]   mac_ivalid_o,
    input  logic [NCH-1:0]   mac_acvalid_i,
    input  logic [NCH*8-1:0] mac_accd_i,
    output logic [NCH*8-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0]      stall_cnt_o
`endif
);

    typedef enum logic [2:0] {
        StIdle, StClear, StAcc, StD1, StD2, StD3, StD4, StCollect
    } state_e;

    state_e             state_q, state_d;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      npix_q, npix_d;
    logic [LW-1:0]      k_q, k_d;
    logic [LW-1:0]      pix_q, pix_d;
    logic [AW-1:0]      stride_q, stride_d;
    logic [AW-1:0]      pix_base_q, pix_base_d;
    logic [AW-1:0]      in_addr_q, in_addr_d;
    logic [AW-1:0]      fil_addr_q, fil_addr_d;
    logic [NCH*8-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               last_k, last_pix, job_ok;
    logic               rdy, aen, acl, ivalid;

    assign last_k   = (k_q == len_q - LW'(1));
    assign last_pix = (pix_q == npix_q - LW'(1));
    assign job_ok   = (len_i != '0) && (npix_i != '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_i && job_ok) state_d = StClear;
            StClear:   state_d = StAcc;
            StAcc:     if (mem_rdy_i && last_k) state_d = StD1;
            StD1:      state_d = StD2;
            StD2:      state_d = StD3;
            // Hold the lane pipeline until the previous result has been taken
            StD3:      if (!out_valid_q) state_d = StD4;
            StD4:      state_d = StCollect;
            StCollect: state_d = last_pix ? StIdle : StAcc;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        rdy    = 1'b0;
        aen    = 1'b0;
        acl    = 1'b0;
        ivalid = 1'b0;
        unique case (state_q)
            StClear: begin
                rdy = 1'b1;
                acl = 1'b1;
            end
            StAcc: begin
                aen    = 1'b1;
                rdy    = mem_rdy_i;
                ivalid = mem_rdy_i;
            end
            StD1, StD2: rdy = 1'b1;
            StD3:       rdy = !out_valid_q;
            StD4: begin
                rdy = 1'b1;
                acl = 1'b1;
            end
            default: ;
        endcase
    end

    assign mac_rdy_o    = {NCH{rdy}};
    assign mac_aen_o    = {NCH{aen}};
    assign mac_acl_o    = {NCH{acl}};
    assign mac_ivalid_o = {NCH{ivalid}};
    assign mac_xreset_o = !reset_i;
    assign busy_o       = (state_q != StIdle);

    always_comb begin
        len_d       = len_q;
        npix_d      = npix_q;
        stride_d    = stride_q;
        pix_base_d  = pix_base_q;
        k_d         = k_q;
        pix_d       = pix_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d      = len_i;
                    npix_d     = npix_i;
                    stride_d   = in_stride_i;
                    pix_base_d = in_base_i;
                    k_d        = '0;
                    pix_d      = '0;
                    done_d     = !job_ok;
                end
            end
            StAcc: begin
                if (mem_rdy_i) k_d = last_k ? '0 : k_q + LW'(1);
            end
            StCollect: begin
                out_data_d  = mac_accd_i;
                out_valid_d = 1'b1;
                if (last_pix) begin
                    done_d = 1'b1;
                end else begin
                    pix_d      = pix_q + LW'(1);
                    pix_base_d = pix_base_q + stride_q;
                end
            end
            default: ;
        endcase
        in_addr_d  = pix_base_d + AW'(k_d);
        fil_addr_d = AW'(k_d);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            len_q       <= '0;
            npix_q      <= '0;
            stride_q    <= '0;
            pix_base_q  <= '0;
            k_q         <= '0;
            pix_q       <= '0;
            in_addr_q   <= '0;
            fil_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            len_q       <= len_d;
            npix_q      <= npix_d;
            stride_q    <= stride_d;
            pix_base_q  <= pix_base_d;
            k_q         <= k_d;
            pix_q       <= pix_d;
            in_addr_q   <= in_addr_d;
            fil_addr_q  <= fil_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign in_addr_o   = in_addr_q;
    assign fil_addr_o  = fil_addr_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign done_o      = done_q;

`ifdef SEQ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == StIdle && start_i) begin
            stall_cnt_d = '0;
        end else if (((state_q == StAcc && !mem_rdy_i) || (state_q == StD3 && out_valid_q))
                     && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    // Every lane must present its result in the collect cycle
    acvalid_in_collect: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q == StCollect) |-> (&mac_acvalid_i));

endmodule
